// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data_mem block.
// Optional build macro: DATA_MEM_WRITE_FIRST_EN (see data_mem_array).
package data_mem_pkg;

   localparam int unsigned WORD_W        = 32;
   localparam int unsigned DEFAULT_DEPTH = 1024;

   typedef enum logic {
      CLEAR,
      RUN
   } dm_state_t;

endpackage

// File: rtl/data_mem_if.sv
// CPU data-memory port: the core drives address/data/enable, the memory returns
// registered load data, the ready flag and the error flag.
interface data_mem_if;
   import data_mem_pkg::*;

   logic [WORD_W-1:0] dm_addr;
   logic [WORD_W-1:0] dm_wdata;
   logic              dm_we;
   logic [WORD_W-1:0] dm_rdata;
   logic              dm_ready;
   logic              dm_err;

   modport master (
      output dm_addr,
      output dm_wdata,
      output dm_we,
      input  dm_rdata,
      input  dm_ready,
      input  dm_err
   );

   modport slave (
      input  dm_addr,
      input  dm_wdata,
      input  dm_we,
      output dm_rdata,
      output dm_ready,
      output dm_err
   );

endinterface

// File: rtl/data_mem_array.sv
// DEPTH x 32 single-port storage with one write port and a registered read port.
// DATA_MEM_WRITE_FIRST_EN selects write-first data on a same-cycle store; default is read-first.
module data_mem_array
   import data_mem_pkg::*;
#(
   parameter  int unsigned DEPTH = DEFAULT_DEPTH,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   // No reset on the storage itself; the owner clears it through the write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_q <= '0;
      end else if (!re) begin
         rdata_q <= '0;
      end else begin
`ifdef DATA_MEM_WRITE_FIRST_EN
         rdata_q <= we ? wdata : mem[addr];
`else
         rdata_q <= mem[addr];
`endif
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem.sv
// Word-addressed data memory with post-reset zero-fill, 1-cycle loads and bad-access flag.
// Read-first by default; define DATA_MEM_WRITE_FIRST_EN for write-first store collisions.
module data_mem
   import data_mem_pkg::*;
#(
   parameter int unsigned       DEPTH     = DEFAULT_DEPTH,
   parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
) (
   input logic       clk,
   input logic       rst,
   data_mem_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);

   dm_state_t         state_q;
   logic [AW-1:0]     clr_idx_q;
   logic              ready_q;
   logic              err_q;

   logic [WORD_W-1:0] off;
   logic [AW-1:0]     idx;
   logic              good;

   logic              mem_we;
   logic              mem_re;
   logic [AW-1:0]     mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [WORD_W-1:0] mem_rdata;

   // Addresses below the base wrap to a huge offset and fail the range test.
   always_comb begin
      off  = bus.dm_addr - BASE_ADDR;
      idx  = off[AW+1:2];
      good = (off[1:0] == 2'b00) && (off[WORD_W-1:AW+2] == '0);
   end

   // Memory is left untouched during a reset cycle.
   always_comb begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = idx;
      mem_wdata = bus.dm_wdata;
      if (rst) begin
         if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_idx_q;
            mem_wdata = '0;
         end else if (good) begin
            mem_we = bus.dm_we;
            mem_re = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               clr_idx_q <= clr_idx_q + AW'(1);
               err_q     <= 1'b0;
               if (clr_idx_q == AW'(DEPTH - 1)) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               ready_q <= 1'b1;
               err_q   <= ~good;
            end
            default: state_q <= CLEAR;
         endcase
      end
   end

   data_mem_array #(
      .DEPTH(DEPTH)
   ) u_array (
      .clk  (clk),
      .rst  (rst),
      .we   (mem_we),
      .re   (mem_re),
      .addr (mem_addr),
      .wdata(mem_wdata),
      .rdata(mem_rdata)
   );

   assign bus.dm_rdata = mem_rdata;
   assign bus.dm_ready = ready_q;
   assign bus.dm_err   = err_q;

endmodule
